dpe_ingress_arb: RTL and testbench
==================================

// Module: dpe_ingress_arb
// PURPOSE
//  - Packet-level round-robin arbiter that merges NUM_SRC AXI-Stream ingress sources onto the single DPE ingress stream.
//  - Sources are the CPU FIFO and the Ethernet MAC RX FIFOs.
//  - Never interleaves packets: a grant is held from the first beat through the beat with tlast.
//  - Tags each output beat with the source index (m_tid), so the DPE can route by origin.
//  - Sits between the source FIFOs and the DPE, in the sys_clk domain.
// PARAMETERS
//  NUM_SRC  5   number of ingress sources; 2..8; index 0 = CPU
//  DATA_W   64  tdata width in bits; multiple of 8
//  KEEP_W   DATA_W/8  tkeep width (derived, do not override)
//  ID_W     $clog2(NUM_SRC)  m_tid width (derived)
// PORTS
//  clk       in   1                 system clock; all logic single-domain
//  arst_n    in   1                 asynchronous active-low reset; deassertion synchronised upstream
//  s_tdata   in   NUM_SRC*DATA_W    source data; source i at [i*DATA_W +: DATA_W]
//  s_tkeep   in   NUM_SRC*KEEP_W    source byte enables
//  s_tvalid  in   NUM_SRC           source valid
//  s_tlast   in   NUM_SRC           source end-of-packet
//  s_tready  out  NUM_SRC           source ready; at most one bit high at any time
//  m_tdata   out  DATA_W            merged data (registered)
//  m_tkeep   out  KEEP_W            merged byte enables (registered)
//  m_tvalid  out  1                 merged valid (registered)
//  m_tlast   out  1                 merged end-of-packet (registered)
//  m_tid     out  ID_W              source index of the current beat (registered)
//  m_tready  in   1                 DPE ready
//  busy      out  1                 high in state PASS
// BEHAVIOUR
//  - Reset values:
//    - Asserting arst_n clears all outputs to 0 immediately: m_* = 0, s_tready = 0, busy = 0.
//    - Reset also sets state = IDLE and rr_ptr = 0.
//    - A packet in flight is truncated without tlast; recovery is the sources' job.
//  - FSM IDLE:
//    - Stays in IDLE while s_tvalid == 0.
//    - Otherwise picks the first set s_tvalid bit scanning upward from rr_ptr, wrapping NUM_SRC-1 -> 0.
//    - Loads gnt (ID_W) with the winner and moves to PASS.
//    - No beat is accepted in IDLE.
//  - FSM PASS:
//    - s_tready[gnt] = ~m_tvalid | m_tready; all other s_tready bits are 0.
//    - A beat is accepted when s_tvalid[gnt] & s_tready[gnt].
//    - Each accepted beat loads the output register, including m_tid = gnt.
//    - On an accepted beat with tlast: rr_ptr = (gnt == NUM_SRC-1) ? 0 : gnt+1, then go to IDLE.
//  - Output register:
//    - m_tvalid clears on m_tready when no new beat is loaded in the same cycle.
//    - While m_tvalid & ~m_tready, m_* hold stable.
//    - Full throughput: one beat per clock while m_tready stays high.
//  - Latency:
//    - s_tvalid rising in IDLE -> grant at +1 clk -> m_tvalid at +2 clk.
//    - Exactly 1 idle bubble between consecutive packets (the IDLE cycle).
//  - Boundary cases:
//    - Simultaneous requests: rr_ptr decides.
//    - Single-beat packets (tlast on the first beat) are legal.
//    - Valid drops mid-packet: grant is held, no timeout.
//    - A source with tvalid low at grant time waits for the next round.
// CONFIGURATION
//  - Macro DPE_ARB_CPU_PRIO_EN:
//    - Defined: in IDLE, source 0 (CPU) wins whenever s_tvalid[0] = 1, regardless of rr_ptr.
//    - Defined: rr_ptr still updates after each granted packet, including CPU grants.
//    - Defined: an Ethernet packet already in PASS is never pre-empted.
//    - Undefined: pure round-robin; all sources are equal.
// TESTING
//  - Reset mid-packet: src2 sends a 4-beat packet; pulse arst_n low on beat 2.
//    -> m_tvalid=0 and s_tready=0 in the same cycle.
//    -> After release: busy=0, rr_ptr=0, and the next src1 request is granted first.
//  - Single source, backpressure: src1 sends a 3-beat packet (tdata 0xA1, 0xA2, 0xA3; tkeep=0xFF; tlast on 0xA3), m_tready=1.
//    -> m_tvalid first high 2 clks after s_tvalid[1].
//    -> Beats appear in order with m_tid=1 and m_tlast on 0xA3.
//    -> busy drops the cycle after the tlast beat.
//  - All 5 sources assert at once, each with a 2-beat packet.
//    -> Grant order 0,1,2,3,4.
//    -> No interleaving of beats between packets.
//    -> Exactly 1 bubble between packets.
//  - m_tready toggles 1,0,0,1 on every beat of a 4-beat packet.
//    -> No beat lost or duplicated.
//    -> m_* stable while stalled.
//    -> s_tready[gnt]=0 whenever m_tvalid & ~m_tready.
//  - DPE_ARB_CPU_PRIO_EN defined: src3 is mid-packet when src0 and src4 request.
//    -> src3 completes first, then src0, then src4.
//    -> Undefined: src3, src4, src0.

Source files
------------

// File: rtl/dpe_ingress_arb.sv
// dpe_ingress_arb: packet-level round-robin arbiter.
// It merges NUM_SRC AXI-Stream sources into one registered DPE ingress stream.
// A grant is held from the first beat of a packet through its tlast beat.
// Each output beat is tagged with its source index on m_tid.
// Optional macro DPE_ARB_CPU_PRIO_EN: when defined, source 0 (CPU) wins every
// IDLE arbitration in which it requests. A packet already in PASS is never
// pre-empted.
module dpe_ingress_arb #(
  parameter int  NUM_SRC = 5,
  parameter int  DATA_W  = 64,
  localparam int KEEP_W  = DATA_W / 8,
  localparam int ID_W    = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [KEEP_W-1:0]         m_tkeep,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  output logic [ID_W-1:0]           m_tid,
  input  logic                      m_tready,
  output logic                      busy
);

  // One extra bit so that rr_ptr + offset can be wrapped without overflow.
  localparam int SUM_W = ID_W + 1;

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   gnt_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   pick;
  logic              found;
  logic [SUM_W-1:0]  sum;

  logic [DATA_W-1:0] src_data [NUM_SRC];
  logic [KEEP_W-1:0] src_keep [NUM_SRC];

  logic              cur_valid;
  logic              cur_last;
  logic              out_free;
  logic              accept;

  // Split the flat source buses into per-source lanes for clean indexing by gnt.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
      assign src_data[gi] = s_tdata[gi*DATA_W +: DATA_W];
      assign src_keep[gi] = s_tkeep[gi*KEEP_W +: KEEP_W];
    end
  endgenerate

  assign cur_valid = s_tvalid[gnt_reg];
  assign cur_last  = s_tlast[gnt_reg];
  // The output register can take a beat when it is empty or being drained.
  assign out_free  = ~m_tvalid | m_tready;
  assign accept    = (state_reg == PASS) & cur_valid & out_free;

  // Round-robin pick: first requesting source scanning upward from rr_ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr_ptr_reg} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_SRC)) begin
        sum = sum - SUM_W'(NUM_SRC);
      end
      if (!found && s_tvalid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[ID_W-1:0];
      end
    end
`ifdef DPE_ARB_CPU_PRIO_EN
    // CPU overrides the rotation, but only when a new packet is being chosen.
    if (s_tvalid[0]) begin
      pick = '0;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: grant on any request, release after the tlast beat is taken.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|s_tvalid) state_next = PASS;
      PASS:    if (accept && cur_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: only the granted source sees ready, and only in PASS.
  always_comb begin
    s_tready = '0;
    busy     = 1'b0;
    if (state_reg == PASS) begin
      s_tready[gnt_reg] = out_free;
      busy              = 1'b1;
    end
  end

  // Grant latch and round-robin pointer; pointer advances past the finished source.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      gnt_reg    <= '0;
      rr_ptr_reg <= '0;
    end else begin
      if (state_reg == IDLE && |s_tvalid) begin
        gnt_reg <= pick;
      end
      if (accept && cur_last) begin
        rr_ptr_reg <= (gnt_reg == ID_W'(NUM_SRC - 1)) ? '0 : gnt_reg + ID_W'(1);
      end
    end
  end

  // Output register: load on accept, drain on m_tready, otherwise hold.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (accept) begin
      m_tdata  <= src_data[gnt_reg];
      m_tkeep  <= src_keep[gnt_reg];
      m_tvalid <= 1'b1;
      m_tlast  <= cur_last;
      m_tid    <= gnt_reg;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dpe_ingress_arb.sv
// Testbench for dpe_ingress_arb: directed packets, scoreboard queue, negedge monitor.
module tb_dpe_ingress_arb;

  localparam int NS = 5;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS*KW-1:0]  s_tkeep;
  logic [NS-1:0]     s_tvalid;
  logic [NS-1:0]     s_tlast;
  logic [NS-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic [IW-1:0]     m_tid;
  logic              m_tready;
  logic              busy;

  logic [DW-1:0]     src_data  [NS];
  logic [KW-1:0]     src_keep  [NS];
  logic              src_valid [NS];
  logic              src_last  [NS];

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [2:0]  id;
  } beat_t;

  beat_t exp_q[$];

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic drv_abort = 1'b0;
  logic gap_chk = 1'b0;

  dpe_ingress_arb #(.NUM_SRC(NS), .DATA_W(DW)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tready (m_tready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always_comb begin
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int i = 0; i < NS; i++) begin
      s_tdata[i*DW +: DW] = src_data[i];
      s_tkeep[i*KW +: KW] = src_keep[i];
      s_tvalid[i]         = src_valid[i];
      s_tlast[i]          = src_last[i];
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=event (t=%0t)", name, $time);
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input int id);
    beat_t b;
    b.d  = d;
    b.k  = k;
    b.l  = l;
    b.id = 3'(id);
    exp_q.push_back(b);
  endtask

  task automatic exp_pkt(input int s, input int n, input logic [7:0] base, input logic [7:0] kl);
    for (int b = 0; b < n; b++) begin
      push_beat(64'(base + 8'(b)), (b == n-1) ? kl : 8'hFF, (b == n-1), s);
    end
  endtask

  // Source driver: presents one beat at a time, advances when ready is seen.
  task automatic drive(input int s, input int n, input logic [7:0] base, input logic [7:0] kl);
    int t;
    for (int b = 0; b < n; b++) begin
      src_valid[s] = 1'b1;
      src_data[s]  = 64'(base + 8'(b));
      src_keep[s]  = (b == n-1) ? kl : 8'hFF;
      src_last[s]  = (b == n-1);
      t = 0;
      forever begin
        @(negedge clk);
        if (drv_abort) begin
          src_valid[s] = 1'b0;
          src_last[s]  = 1'b0;
          return;
        end
        if (s_tready[s]) break;
        t++;
        if (t > 500) begin
          timeout_fail("src_ready_wait");
          src_valid[s] = 1'b0;
          src_last[s]  = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail(name);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name, input logic need_last, output logic ok);
    int t = 0;
    ok = 1'b0;
    while (t < 200) begin
      @(negedge clk);
      if (m_tvalid && (!need_last || m_tlast)) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    if (!ok) timeout_fail(name);
  endtask

  // Monitor / scoreboard: compares each output beat transferred, checks stalls and gaps.
  initial begin
    beat_t            e;
    logic             hold_chk = 1'b0;
    logic [76:0]      hold_val = '0;
    logic             have_end = 1'b0;
    logic             next_first = 1'b1;
    int               last_end = 0;
    forever begin
      @(negedge clk);
      if (!gap_chk) have_end = 1'b0;
      if (!arst_n) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          chk("stall_stable", {m_tdata, m_tkeep, m_tlast, m_tid, m_tvalid}, hold_val);
          hold_chk = 1'b0;
        end
        if (m_tvalid && !m_tready) begin
          chk("stall_s_tready", s_tready, '0);
          hold_val = {m_tdata, m_tkeep, m_tlast, m_tid, m_tvalid};
          hold_chk = 1'b1;
        end
        if (m_tvalid && m_tready) begin
          $display("beat: tid=%0d data=%h keep=%h last=%0b", m_tid, m_tdata, m_tkeep, m_tlast);
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {m_tdata, m_tkeep, m_tlast, m_tid}, '0);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {m_tdata, m_tkeep, m_tlast, m_tid}, e);
          end
          if (gap_chk && have_end && next_first) begin
            chk("pkt_gap", cyc - last_end, 2);
          end
          next_first = m_tlast;
          if (m_tlast) begin
            last_end = cyc;
            have_end = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int     c0;
    int     k;
    logic   ok;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < NS; i++) begin
      src_data[i]  = '0;
      src_keep[i]  = '0;
      src_valid[i] = 1'b0;
      src_last[i]  = 1'b0;
    end
    m_tready = 1'b1;
    arst_n   = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid_last", {m_tvalid, m_tlast}, 2'b00);
    chk("rst_s_tready", s_tready, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_data", {m_tdata, m_tkeep, m_tid}, '0);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // All five sources at once, 2-beat packets: order 0..4, one bubble between packets.
    gap_chk = 1'b1;
    exp_pkt(0, 2, 8'h10, 8'h0F);
    exp_pkt(1, 2, 8'h20, 8'h0F);
    exp_pkt(2, 2, 8'h30, 8'h0F);
    exp_pkt(3, 2, 8'h40, 8'h0F);
    exp_pkt(4, 2, 8'h50, 8'h0F);
    fork
      drive(0, 2, 8'h10, 8'h0F);
      drive(1, 2, 8'h20, 8'h0F);
      drive(2, 2, 8'h30, 8'h0F);
      drive(3, 2, 8'h40, 8'h0F);
      drive(4, 2, 8'h50, 8'h0F);
    join_none
    wait_drain("all5_drain");
    gap_chk = 1'b0;

    // Single source src1: latency 2, in-order beats, busy low once tlast is taken.
    c0 = cyc;
    exp_pkt(1, 3, 8'hA1, 8'hFF);
    fork
      drive(1, 3, 8'hA1, 8'hFF);
    join_none
    wait_out("latency_wait", 1'b0, ok);
    if (ok) chk("first_beat_latency", cyc - c0, 2);
    wait_out("tlast_wait", 1'b1, ok);
    if (ok) chk("busy_after_tlast", busy, 1'b0);
    wait_drain("src1_drain");

    // Reset mid-packet: src2 4-beat packet, reset while beat 2 is offered.
    push_beat(64'h60, 8'hFF, 1'b0, 2);
    fork
      drive(2, 4, 8'h60, 8'h0F);
    join_none
    wait_out("rstmid_wait", 1'b0, ok);
    #2;
    arst_n    = 1'b0;
    drv_abort = 1'b1;
    #1;
    chk("rstmid_m_tvalid", m_tvalid, 1'b0);
    chk("rstmid_s_tready", s_tready, '0);
    chk("rstmid_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    drv_abort = 1'b0;
    arst_n    = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_rr_ptr", dut.rr_ptr_reg, '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    exp_pkt(1, 2, 8'h70, 8'h0F);
    exp_pkt(3, 2, 8'h80, 8'h0F);
    fork
      drive(1, 2, 8'h70, 8'h0F);
      drive(3, 2, 8'h80, 8'h0F);
    join_none
    wait_drain("post_rst_drain");

    // Backpressure: m_tready follows 1,0,0,1 during a 4-beat src0 packet.
    exp_pkt(0, 4, 8'h90, 8'h0F);
    fork
      drive(0, 4, 8'h90, 8'h0F);
    join_none
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      m_tready = pat[k % 4];
      k++;
    end
    m_tready = 1'b1;
    wait_drain("bp_drain");

    // src3 mid-packet when src0 and src4 request.
    exp_pkt(3, 4, 8'hB0, 8'h0F);
`ifdef DPE_ARB_CPU_PRIO_EN
    exp_pkt(0, 2, 8'hC0, 8'h0F);
    exp_pkt(4, 2, 8'hD0, 8'h0F);
`else
    exp_pkt(4, 2, 8'hD0, 8'h0F);
    exp_pkt(0, 2, 8'hC0, 8'h0F);
`endif
    fork
      drive(3, 4, 8'hB0, 8'h0F);
    join_none
    wait_out("prio_wait", 1'b0, ok);
    @(posedge clk);
    #1;
    fork
      drive(0, 2, 8'hC0, 8'h0F);
      drive(4, 2, 8'hD0, 8'h0F);
    join_none
    wait_drain("prio_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
